// File: rtl/gf180mcu_sync_deglitch_rx_if.sv
// Signal bundle for the synchronizing deglitch receiver: async level in, enable,
// clean level out plus edge strobes and busy flag.
interface gf180mcu_sync_deglitch_rx_if;
  logic I;
  logic EN;
  logic Z;
  logic RISE;
  logic FALL;
  logic BUSY;

  modport master (output I, output EN, input Z, input RISE, input FALL, input BUSY);
  modport slave  (input I, input EN, output Z, output RISE, output FALL, output BUSY);
endinterface

// File: rtl/gf180mcu_sync_deglitch_rx.sv
// Synchronizes an asynchronous level into the CLK domain and only lets it reach Z
// after FILT_CNT consecutive disagreeing samples; RISE/FALL strobe on each Z flip.
module gf180mcu_sync_deglitch_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CNT    = 4,
  parameter int unsigned CNT_W       = 3,
  parameter bit          RESET_VAL   = 1'b0
) (
  input logic                          CLK,
  input logic                          RN,
  gf180mcu_sync_deglitch_rx_if.slave   bus
);

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  state_t                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   z_r, z_nxt_s;
  logic                   rise_r, rise_nxt_s;
  logic                   fall_r, fall_nxt_s;
  logic                   busy_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Metastability chain; runs independently of EN
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.I};
    end
  end

  // Qualify FSM next-state: a flip of Z needs FILT_CNT consecutive mismatches
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    z_nxt_s     = z_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      STABLE: begin
        if (bus.EN && (sync_s != z_r)) begin
          if (FILT_CNT == 1) begin
            z_nxt_s    = sync_s;
            rise_nxt_s = sync_s;
            fall_nxt_s = ~sync_s;
            cnt_nxt_s  = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = QUALIFY;
            cnt_nxt_s   = CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      QUALIFY: begin
        if (!bus.EN) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (sync_s == z_r) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(FILT_CNT - 1)) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          z_nxt_s     = sync_s;
          rise_nxt_s  = sync_s;
          fall_nxt_s  = ~sync_s;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = STABLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, level and strobe registers; reset aborts any qualify without a pulse
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r <= STABLE;
      cnt_r   <= {CNT_W{1'b0}};
      z_r     <= RESET_VAL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      z_r     <= z_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      busy_r  <= (state_nxt_s == QUALIFY);
    end
  end

  assign bus.Z    = z_r;
  assign bus.RISE = rise_r;
  assign bus.FALL = fall_r;
  assign bus.BUSY = busy_r;

endmodule
